monpro_stream: RTL and testbench

MONPRO_STREAM -- requirements
Module: monpro_stream

---
 rtl/monpro_stream_if.sv | 25 ++
 rtl/monpro_stream.sv | 140 ++++++++++++++
 tb/tb_monpro_stream.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/monpro_stream_if.sv
// Streaming operand/result bus for the Montgomery multiplier.
interface monpro_stream_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  start_input;
  logic [DATA_WIDTH-1:0] a_input;
  logic [DATA_WIDTH-1:0] b_input;
  logic [DATA_WIDTH-1:0] n_input;
  logic                  busy;
  logic                  result_valid;
  logic                  get_result;
  logic [DATA_WIDTH-1:0] res_out;

  // Producer/consumer side (drives operands and acknowledges results).
  modport master (
    output start_input, a_input, b_input, n_input, get_result,
    input  busy, result_valid, res_out
  );

  // Multiplier side.
  modport slave (
    input  start_input, a_input, b_input, n_input, get_result,
    output busy, result_valid, res_out
  );
endinterface

// File: rtl/monpro_stream.sv
// Bit-serial Montgomery product S = A*B*2^-OP mod N with word-streamed operands and result.
module monpro_stream #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_WORDS  = 16
) (
  input logic           clk,
  input logic           reset,
  monpro_stream_if.slave bus
);
  localparam int unsigned OP    = DATA_WIDTH * NUM_WORDS;
  localparam int unsigned WordW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned BitW  = (OP > 1) ? $clog2(OP) : 1;
  localparam logic [WordW-1:0] LastWord = WordW'(NUM_WORDS - 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(OP - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StCompute, StReduce, StOutput} state_e;

  state_e           state_q, state_d;
  logic [OP-1:0]    a_q, a_d;
  logic [OP-1:0]    b_q, b_d;
  logic [OP-1:0]    n_q, n_d;
  // Two guard bits: the pre-shift sum S + B + N can reach just under 4N.
  logic [OP+1:0]    s_q, s_d;
  logic [WordW-1:0] word_q, word_d;
  logic [BitW-1:0]  bit_q, bit_d;

  logic [OP+1:0]    sum_add;
  logic [OP+1:0]    sum_red;
  logic [OP+1:0]    s_step;

  // One radix-2 Montgomery iteration on the current accumulator.
  always_comb begin
    sum_add = s_q + (a_q[bit_q] ? {2'b00, b_q} : '0);
    sum_red = sum_add[0] ? (sum_add + {2'b00, n_q}) : sum_add;
    s_step  = sum_red >> 1;
  end

  // Next-state: operand capture, iteration control, final subtract, result handoff.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    s_d     = s_q;
    word_d  = word_q;
    bit_d   = bit_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start_input) begin
          a_d[DATA_WIDTH-1:0] = bus.a_input;
          b_d[DATA_WIDTH-1:0] = bus.b_input;
          n_d[DATA_WIDTH-1:0] = bus.n_input;
          if (NUM_WORDS == 1) begin
            state_d = StCompute;
            s_d     = '0;
            bit_d   = '0;
            word_d  = '0;
          end else begin
            state_d = StLoad;
            word_d  = WordW'(1);
          end
        end
      end
      StLoad: begin
        if (bus.start_input) begin
          a_d[word_q*DATA_WIDTH +: DATA_WIDTH] = bus.a_input;
          b_d[word_q*DATA_WIDTH +: DATA_WIDTH] = bus.b_input;
          n_d[word_q*DATA_WIDTH +: DATA_WIDTH] = bus.n_input;
          if (word_q == LastWord) begin
            state_d = StCompute;
            s_d     = '0;
            bit_d   = '0;
            word_d  = '0;
          end else begin
            word_d = word_q + WordW'(1);
          end
        end
      end
      StCompute: begin
        s_d = s_step;
        if (bit_q == LastBit) begin
          state_d = StReduce;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BitW'(1);
        end
      end
      StReduce: begin
        if (s_q >= {2'b00, n_q}) begin
          s_d = s_q - {2'b00, n_q};
        end
        state_d = StOutput;
        word_d  = '0;
      end
      StOutput: begin
        if (bus.get_result) begin
          if (word_q == LastWord) begin
            state_d = StIdle;
            word_d  = '0;
          end else begin
            word_d = word_q + WordW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset that abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      s_q     <= '0;
      word_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      s_q     <= s_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
    end
  end

  // Status and result word select; res_out is forced to zero outside OUTPUT.
  always_comb begin
    bus.busy         = (state_q != StIdle);
    bus.result_valid = (state_q == StOutput);
    bus.res_out      = '0;
    if (state_q == StOutput) begin
      bus.res_out = s_q[word_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end
endmodule

// File: tb/tb_monpro_stream.sv
// Self-checking bench for monpro_stream at DATA_WIDTH=4, NUM_WORDS=2 (OP=8).
module tb_monpro_stream;
  localparam int unsigned DW  = 4;
  localparam int unsigned NW  = 2;
  localparam int unsigned OP  = DW * NW;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  monpro_stream_if #(.DATA_WIDTH(DW)) bus ();

  monpro_stream #(
    .DATA_WIDTH(DW),
    .NUM_WORDS (NW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the unique x in [0,N) with x*2^OP == A*B (mod N), found by search.
  function automatic logic [7:0] ref_mont(input int unsigned a, input int unsigned b,
                                          input int unsigned n);
    int unsigned p;
    logic [7:0]  r;
    p = (a * b) % n;
    r = '0;
    for (int unsigned x = 0; x < n; x++) begin
      if (((x << OP) % n) == p) begin
        r = x[7:0];
        break;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n,
                          input int w);
    bus.a_input = (w == 0) ? a[3:0] : a[7:4];
    bus.b_input = (w == 0) ? b[3:0] : b[7:4];
    bus.n_input = (w == 0) ? n[3:0] : n[7:4];
  endtask

  // Streams both words, optionally stalling `gap` cycles between them with junk on the bus.
  task automatic load_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n,
                         input int gap);
    bus.start_input = 1'b1;
    set_word(a, b, n, 0);
    step();
    chk("busy_after_w0", bus.busy, 1);
    bus.start_input = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.a_input = DW'($urandom);
      bus.b_input = DW'($urandom);
      bus.n_input = DW'($urandom);
      step();
      chk("busy_stall", bus.busy, 1);
      chk("valid_stall", bus.result_valid, 0);
    end
    bus.start_input = 1'b1;
    set_word(a, b, n, 1);
    step();
    bus.start_input = 1'b0;
  endtask

  // Counts cycles from last capture to result_valid, poking ignored inputs meanwhile.
  task automatic wait_result(input bit noise);
    int cycles;
    cycles = 1;
    while (!bus.result_valid && cycles < 40) begin
      chk("res_zero_wait", bus.res_out, 0);
      if (noise) begin
        bus.start_input = 1'($urandom);
        bus.get_result  = 1'($urandom);
        bus.a_input     = DW'($urandom);
        bus.b_input     = DW'($urandom);
        bus.n_input     = DW'($urandom);
      end
      step();
      cycles++;
    end
    bus.start_input = 1'b0;
    bus.get_result  = 1'b0;
    // cycles started at 1 because load_op already consumed the capture edge.
    chk("latency", cycles - 1, OP + 1);
  endtask

  task automatic read_result(input logic [7:0] exp, input bit hold);
    if (hold) begin
      for (int h = 0; h < 5; h++) begin
        bus.start_input = 1'($urandom);
        bus.a_input     = DW'($urandom);
        step();
        chk("hold_valid", bus.result_valid, 1);
        chk("hold_word0", bus.res_out, exp[3:0]);
      end
      bus.start_input = 1'b0;
    end
    for (int w = 0; w < 2; w++) begin
      chk("valid_out", bus.result_valid, 1);
      chk("busy_out", bus.busy, 1);
      chk("res_word", bus.res_out, (w == 0) ? exp[3:0] : exp[7:4]);
      bus.get_result = 1'b1;
      step();
      bus.get_result = 1'b0;
    end
    chk("valid_done", bus.result_valid, 0);
    chk("busy_done", bus.busy, 0);
    chk("res_done", bus.res_out, 0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n,
                        input int gap, input bit noise, input bit hold);
    load_op(a, b, n, gap);
    wait_result(noise);
    read_result(ref_mont(a, b, n), hold);
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_valid"}, bus.result_valid, 0);
    chk({tag, "_res"}, bus.res_out, 0);
  endtask

  initial begin
    logic [7:0] ra, rb, rn;
    int         seen;
    n_checks        = 0;
    n_fail          = 0;
    reset           = 1'b1;
    bus.start_input = 1'b0;
    bus.get_result  = 1'b0;
    bus.a_input     = '0;
    bus.b_input     = '0;
    bus.n_input     = '0;
    step();
    step();
    idle_checks("reset");
    reset = 1'b0;
    step();
    idle_checks("idle");

    // Directed cases.
    run_op(8'h07, 8'h0B, 8'h0F, 0, 0, 0);
    run_op(8'hFE, 8'hFE, 8'hFF, 0, 0, 0);
    run_op(8'h00, 8'h0E, 8'h0F, 0, 0, 0);
    run_op(8'h07, 8'h0B, 8'h0F, 3, 0, 0);
    run_op(8'h07, 8'h0B, 8'h0F, 0, 1, 1);

    // Reset before iteration 4 completes, with start asserted in the same cycle.
    load_op(8'hFE, 8'hFE, 8'hFF, 0);
    for (int i = 0; i < 4; i++) step();
    reset           = 1'b1;
    bus.start_input = 1'b1;
    step();
    reset           = 1'b0;
    bus.start_input = 1'b0;
    idle_checks("rst_compute");
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.result_valid || bus.busy) seen++;
    end
    chk("rst_no_result", seen, 0);
    run_op(8'h07, 8'h0B, 8'h0F, 0, 0, 0);

    // Reset mid-load, then a fresh operation must not inherit the stale word.
    bus.start_input = 1'b1;
    set_word(8'hFE, 8'hFE, 8'hFF, 0);
    step();
    reset = 1'b1;
    step();
    reset           = 1'b0;
    bus.start_input = 1'b0;
    idle_checks("rst_load");
    run_op(8'h35, 8'h5A, 8'h63, 1, 0, 0);

    // Reset in OUTPUT with get_result high: reset wins, nothing presented afterwards.
    load_op(8'h12, 8'h34, 8'h57, 0);
    wait_result(0);
    reset          = 1'b1;
    bus.get_result = 1'b1;
    step();
    reset          = 1'b0;
    bus.get_result = 1'b0;
    idle_checks("rst_output");
    step();
    idle_checks("rst_output2");

    // Randomized operands with random stalls, ignored-input noise and output holds.
    for (int t = 0; t < 25; t++) begin
      rn = 8'($urandom_range(0, 127) * 2 + 1);
      ra = 8'($urandom_range(0, int'(rn) - 1));
      rb = 8'($urandom_range(0, int'(rn) - 1));
      run_op(ra, rb, rn, $urandom_range(0, 3), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
